// File: rtl/joy_serializer.sv
// joy_serializer: parallel controller inputs to a serial reader stream.
// Optional autofire on button 4 is enabled by defining JOY_SER_AUTOFIRE_EN.
module joy_serializer #(
   parameter int LEAD_BITS   = 1,
   parameter int SYNC_STAGES = 2,
   parameter int AF_PERIOD   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [11:0] joy1_n,
   input  logic [11:0] joy2_n,
   input  logic        joy_clk,
   input  logic        joy_load,
   output logic        joy_data,
   output logic        frame_done
);

   localparam int TOTAL = LEAD_BITS + 24;
   localparam int CW    = $clog2(TOTAL + 1);
   localparam logic [CW-1:0] CNT_IDLE = CW'(TOTAL);
   localparam logic [CW-1:0] CNT_LAST = CW'(TOTAL - 1);

   logic [SYNC_STAGES-1:0] jclk_sync_q;
   logic [SYNC_STAGES-1:0] jload_sync_q;
   logic                   jclk_dly_q;
   logic                   clk_s;
   logic                   load_s;
   logic                   rise;

   logic [TOTAL-1:0] sr_q, sr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             done_d;
   logic             joy_data_q;
   logic             frame_done_q;

   logic [11:0]      j1_m, j2_m;
   logic [23:0]      frame_w;

   assign clk_s  = jclk_sync_q[SYNC_STAGES-1];
   assign load_s = jload_sync_q[SYNC_STAGES-1];
   assign rise   = clk_s & ~jclk_dly_q;

   // Synchronize the reader strobes and keep one delayed copy of the clock.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         jclk_sync_q  <= '0;
         jload_sync_q <= '1;
         jclk_dly_q   <= 1'b0;
      end else begin
         jclk_sync_q  <= (jclk_sync_q << 1) | SYNC_STAGES'(joy_clk);
         jload_sync_q <= (jload_sync_q << 1) | SYNC_STAGES'(joy_load);
         jclk_dly_q   <= clk_s;
      end
   end

`ifdef JOY_SER_AUTOFIRE_EN
   localparam int AFW = (AF_PERIOD > 1) ? $clog2(AF_PERIOD) : 1;

   logic [AFW-1:0] af_cnt_q;
   logic           af_phase_q;
   logic           af_mask_q;
   logic           jload_dly_q;
   logic           load_fall;

   assign load_fall = jload_dly_q & ~load_s;

   // Count loads and flip the autofire phase every AF_PERIOD loads.
   // The mask is frozen during a load so the frame uses the phase
   // that was in effect when that load began.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         af_cnt_q    <= '0;
         af_phase_q  <= 1'b0;
         af_mask_q   <= 1'b0;
         jload_dly_q <= 1'b1;
      end else begin
         jload_dly_q <= load_s;
         if (load_fall) begin
            if (af_cnt_q == AFW'(AF_PERIOD - 1)) begin
               af_cnt_q   <= '0;
               af_phase_q <= ~af_phase_q;
            end else begin
               af_cnt_q <= af_cnt_q + AFW'(1);
            end
         end
         if (load_s) begin
            af_mask_q <= af_phase_q;
         end
      end
   end

   // Force button 4 released while the autofire phase is high.
   always_comb begin
      j1_m    = joy1_n;
      j2_m    = joy2_n;
      j1_m[4] = joy1_n[4] | af_mask_q;
      j2_m[4] = joy2_n[4] | af_mask_q;
   end
`else
   // Buttons pass through unmodified.
   always_comb begin
      j1_m = joy1_n;
      j2_m = joy2_n;
   end
`endif

   assign frame_w = {j1_m[8], j1_m[6], j1_m[5:0],
                     j2_m[8], j2_m[6], j2_m[5:0],
                     j2_m[10], j2_m[11], j2_m[9], j2_m[7],
                     j1_m[10], j1_m[11], j1_m[9], j1_m[7]};

   // Load has priority; otherwise shift on each reader clock edge
   // until the counter saturates at the frame length.
   always_comb begin
      sr_d   = sr_q;
      cnt_d  = cnt_q;
      done_d = 1'b0;
      if (!load_s) begin
         sr_d  = {{LEAD_BITS{1'b1}}, frame_w};
         cnt_d = '0;
      end else if (rise && (cnt_q != CNT_IDLE)) begin
         sr_d   = {sr_q[TOTAL-2:0], 1'b1};
         cnt_d  = cnt_q + CW'(1);
         done_d = (cnt_q == CNT_LAST);
      end
   end

   // Frame state and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sr_q         <= '1;
         cnt_q        <= CNT_IDLE;
         joy_data_q   <= 1'b1;
         frame_done_q <= 1'b0;
      end else begin
         sr_q         <= sr_d;
         cnt_q        <= cnt_d;
         joy_data_q   <= sr_d[TOTAL-1];
         frame_done_q <= done_d;
      end
   end

   assign joy_data   = joy_data_q;
   assign frame_done = frame_done_q;

endmodule

// File: doc/joy_serializer.md
JOY_SERIALIZER -- requirements
Module: joy_serializer

Interface
REQ-001 SHALL have parameter LEAD_BITS, default 1, the number of pad bits (value 1) shifted out before the 24-bit frame.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the synchronizer depth for joy_clk and joy_load.
REQ-003 SHALL have parameter AF_PERIOD, default 4, the number of loads per autofire half-period (used only under REQ-024).
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all state is clocked on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port joy1_n, input, 12 bits: player-1 controls, active-low (1 = released).
REQ-007 SHALL have port joy2_n, input, 12 bits: player-2 controls, active-low.
REQ-008 SHALL have port joy_clk, input, 1 bit: serial shift clock from the reader, asynchronous to clk.
REQ-009 SHALL have port joy_load, input, 1 bit: parallel-load strobe from the reader, active-low, asynchronous to clk.
REQ-010 SHALL have port joy_data, output, 1 bit: serial data to the reader, registered.
REQ-011 SHALL have port frame_done, output, 1 bit: one-clk pulse when the last frame bit has been shifted out.

Function
REQ-012 SHALL pass joy_clk and joy_load through SYNC_STAGES flip-flops each, then detect joy_clk rising edges by comparing the last stage with one extra delayed copy.
REQ-013 SHALL hold a shift register of LEAD_BITS+24 bits; joy_data is its output bit, registered.
REQ-014 SHALL, while the synchronized load is 0, reload the shift register every clk with LEAD_BITS ones followed by this frame order: joy1_n[8], joy1_n[6], joy1_n[5:0] (MSB first), joy2_n[8], joy2_n[6], joy2_n[5:0], joy2_n[10], joy2_n[11], joy2_n[9], joy2_n[7], joy1_n[10], joy1_n[11], joy1_n[9], joy1_n[7].
REQ-015 SHALL also, while load is 0, clear the bit counter; joy_clk edges during load SHALL be ignored (load wins on simultaneous events).
REQ-016 SHALL, on each synchronized joy_clk rising edge with load at 1, shift by one position, fill with 1 and increment the bit counter.
REQ-017 SHALL saturate the bit counter at LEAD_BITS+24; any further edges SHALL keep joy_data at 1 (idle), with no wrap-around.
REQ-018 SHALL assert frame_done for exactly one clk when the counter reaches LEAD_BITS+24, and once per frame only.
REQ-019 SHALL update joy_data within SYNC_STAGES+2 clk cycles of a joy_clk rising edge; the clk frequency SHALL be at least 8x the joy_clk frequency.
REQ-020 SHALL sample joy1_n/joy2_n only during load; input changes during shifting SHALL NOT affect the frame in flight.

Reset
REQ-021 SHALL, while reset is 1, force: shift register all ones; joy_data=1; frame_done=0; bit counter=LEAD_BITS+24 (idle); joy_clk synchronizer=0; joy_load synchronizer=1.
REQ-022 SHALL abort any frame in progress on reset, including reset asserted mid-frame, with no spurious frame_done.
REQ-023 SHALL, after reset deasserts, output 1 until the first load is seen.

Configuration
REQ-024 SHALL, with JOY_SER_AUTOFIRE_EN defined, count synchronized load falling edges modulo AF_PERIOD and toggle a phase bit on each wrap; while the phase is 1, bit 4 of each player SHALL be reported as 1 (released) even if pressed.
REQ-025 SHALL, without JOY_SER_AUTOFIRE_EN, omit the load counter and phase bit and report bit 4 unmodified.
REQ-026 SHALL reset the autofire counter and phase to 0 on reset.

Verification
REQ-027 SHALL cover: reset, then joy1_n=12'hFFE, joy2_n=12'hFFF, load pulse, then 25 joy_clk edges -> after the lead bit the sampled stream is all 1 except frame position 7 (joy1_n[0]) = 0; frame_done pulses once.
REQ-028 SHALL cover: joy2_n=12'h7FF (bit 11 = 0) -> frame position 17 = 0, all others 1.
REQ-029 SHALL cover: 30 joy_clk edges after load -> edges 26-30 give joy_data=1, with a single frame_done.
REQ-030 SHALL cover: joy1_n changed from 12'hFFF to 12'h000 at edge 5 -> the current frame still reads all 1; the next frame reads 0 in the joy1 positions.
REQ-031 SHALL cover: reset asserted at edge 10 -> joy_data=1 immediately, no frame_done; a new load reproduces the full frame.
REQ-032 SHALL cover (JOY_SER_AUTOFIRE_EN, AF_PERIOD=4): joy1_n[4] held at 0 for 16 loads -> position 3 reads 0 for loads 1-4, 1 for loads 5-8, 0 for loads 9-12, 1 for loads 13-16.
